bus_arbiter2: RTL and testbench

- Two-requester round-robin arbiter and sequencer for the processor's shared 32-bit 2:1 datapath mux.
- Drives the mux select, registers the selected word into a one-entry output stage, and presents it on a valid/ready interface to the shared consumer (register-file write port or memory port).
- Supports locked multi-beat bursts with a bounded burst length so that neither requester starves.

---
 rtl/bus_arbiter2.sv | 114 +++++++++++
 tb/tb_bus_arbiter2.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/bus_arbiter2.sv
// Two-requester round-robin arbiter for the shared 2:1 datapath mux.
// It has a one-entry registered output stage and lock-based bursts with a bounded length.
module bus_arbiter2 #(
    parameter int unsigned DWIDTH    = 32,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned CWIDTH    = $clog2(MAX_BURST + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic              lock_a,
    input  logic [DWIDTH-1:0] data_a,
    output logic              ack_a,
    input  logic              req_b,
    input  logic              lock_b,
    input  logic [DWIDTH-1:0] data_b,
    output logic              ack_b,
    output logic              sel,
    output logic              out_valid,
    output logic [DWIDTH-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        owner
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StOwnA = 2'b01,
        StOwnB = 2'b10
    } owner_e;

    owner_e              owner_q;
    logic                prio_q;
    logic                sel_q;
    logic [CWIDTH-1:0]   burst_cnt_q;
    logic                out_valid_q;
    logic [DWIDTH-1:0]   out_data_q;

    logic                choice_valid;
    logic                choice_b;
    logic                take;
    logic                capture;
    logic                lock_sel;
    logic [CWIDTH-1:0]   next_cnt;
    logic                keep_own;

    always_comb begin
        choice_valid = 1'b0;
        choice_b     = 1'b0;
        case (owner_q)
            StIdle: begin
                if (req_a && req_b) begin
                    choice_valid = 1'b1;
                    choice_b     = prio_q;
                end else if (req_a) begin
                    choice_valid = 1'b1;
                end else if (req_b) begin
                    choice_valid = 1'b1;
                    choice_b     = 1'b1;
                end
            end
            // The owner alone may be granted; the other requester waits.
            StOwnA: choice_valid = req_a;
            StOwnB: begin
                choice_valid = req_b;
                choice_b     = 1'b1;
            end
            default: ;
        endcase
    end

    assign take     = !out_valid_q || out_ready;
    assign capture  = take && choice_valid && !rst;
    assign ack_a    = capture && !choice_b;
    assign ack_b    = capture && choice_b;
    assign sel      = rst ? 1'b0 : (choice_valid ? choice_b : sel_q);
    assign lock_sel = choice_b ? lock_b : lock_a;
    assign next_cnt = burst_cnt_q + 1'b1;
    // The beat that brings the count to MAX_BURST releases ownership even if still locked.
    assign keep_own = lock_sel && (32'(next_cnt) < MAX_BURST);

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q     <= StIdle;
            prio_q      <= 1'b0;
            sel_q       <= 1'b0;
            burst_cnt_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (choice_valid) begin
                sel_q <= choice_b;
            end
            if (capture) begin
                out_data_q  <= choice_b ? data_b : data_a;
                out_valid_q <= 1'b1;
                if (keep_own) begin
                    owner_q     <= choice_b ? StOwnB : StOwnA;
                    burst_cnt_q <= next_cnt;
                end else begin
                    owner_q     <= StIdle;
                    burst_cnt_q <= '0;
                    prio_q      <= !choice_b;
                end
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_bus_arbiter2.sv
// Directed bench for bus_arbiter2. It covers reset, alternation, stall, bounded bursts,
// early burst end and reset while a burst is in progress.
module tb_bus_arbiter2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_a, lock_a, ack_a;
    logic        req_b, lock_b, ack_b;
    logic [31:0] data_a, data_b, out_data;
    logic        sel, out_valid, out_ready;
    logic [1:0]  owner;

    int n_checks = 0;
    int n_pass   = 0;

    bus_arbiter2 #(.DWIDTH(32), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_a     (req_a),
        .lock_a    (lock_a),
        .data_a    (data_a),
        .ack_a     (ack_a),
        .req_b     (req_b),
        .lock_b    (lock_b),
        .data_b    (data_b),
        .ack_b     (ack_b),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .owner     (owner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Advance one clock edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the combinational grant outputs for the current cycle.
    task automatic grant(input string tag, input logic ea, input logic eb, input logic es);
        #1;
        check({tag, ".ack_a"}, 32'(ack_a), 32'(ea));
        check({tag, ".ack_b"}, 32'(ack_b), 32'(eb));
        check({tag, ".sel"},   32'(sel),   32'(es));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_a = 1'b0; lock_a = 1'b0; data_a = '0;
        req_b = 1'b0; lock_b = 1'b0; data_b = '0; out_ready = 1'b1;

        // 1: reset state, then a single A word
        req_a = 1'b1; req_b = 1'b1;
        tick();
        grant("rst_hold", 1'b0, 1'b0, 1'b0);
        tick();
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.out_data",  out_data,       32'd0);
        check("rst.owner",     32'(owner),     32'd0);
        rst = 1'b0; req_b = 1'b0; data_a = 32'hFFFF_FFFF;
        grant("t1", 1'b1, 1'b0, 1'b0);
        tick();
        check("t1.out_valid", 32'(out_valid), 32'd1);
        check("t1.out_data",  out_data,       32'hFFFF_FFFF);
        req_a = 1'b0;
        tick();
        check("t1.drain", 32'(out_valid), 32'd0);

        // 2: unlocked alternation, starting with A after reset
        do_reset();
        req_a = 1'b1; req_b = 1'b1;
        data_a = 32'h0123_4567; data_b = 32'hFEDC_BA98;
        for (int i = 0; i < 4; i++) begin
            grant("t2", (i % 2) == 0, (i % 2) == 1, (i % 2) == 1);
            tick();
            check("t2.out_data", out_data, ((i % 2) == 0) ? 32'h0123_4567 : 32'hFEDC_BA98);
            check("t2.out_valid", 32'(out_valid), 32'd1);
        end

        // 3: output stall blocks acks and freezes the output word
        req_a = 1'b0; out_ready = 1'b0; data_b = 32'hCAFE_F00D;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t3.stall_ack_b", 32'(ack_b), 32'd0);
            tick();
            check("t3.stall_data", out_data, 32'hFEDC_BA98);
        end
        out_ready = 1'b1;
        grant("t3.release", 1'b0, 1'b1, 1'b1);
        tick();
        check("t3.out_data", out_data, 32'hCAFE_F00D);
        req_b = 1'b0;
        tick();

        // 4: A locked for 7 beats, MAX_BURST=4 forces a release after the 4th; prio is A here
        req_a = 1'b1; lock_a = 1'b1; req_b = 1'b1; data_a = 32'hA000_0004; data_b = 32'hB000_0004;
        for (int i = 1; i <= 7; i++) begin
            if (i == 7) lock_a = 1'b0;
            grant("t4", i != 5, i == 5, i == 5);
            tick();
            check("t4.owner", 32'(owner), (i <= 3 || i == 6) ? 32'd1 : 32'd0);
            check("t4.out_data", out_data, (i == 5) ? 32'hB000_0004 : 32'hA000_0004);
        end

        // 5: A burst ended early on its 3rd beat; B gets the next grant
        req_b = 1'b0; lock_a = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            if (i == 2) req_b = 1'b1;
            if (i == 3) lock_a = 1'b0;
            grant("t5", 1'b1, 1'b0, 1'b0);
            tick();
            check("t5.owner", 32'(owner), (i == 3) ? 32'd0 : 32'd1);
        end
        lock_a = 1'b1;
        grant("t5.next", 1'b0, 1'b1, 1'b1);
        tick();

        // 6: reset while B owns the bus with a word pending
        req_a = 1'b0; lock_a = 1'b0; req_b = 1'b1; lock_b = 1'b1; data_b = 32'hB000_0006;
        grant("t6.own_b", 1'b0, 1'b1, 1'b1);
        tick();
        check("t6.owner_b", 32'(owner), 32'd2);
        check("t6.valid_b", 32'(out_valid), 32'd1);
        rst = 1'b1; req_a = 1'b1;
        grant("t6.in_rst", 1'b0, 1'b0, 1'b0);
        tick();
        check("t6.out_valid", 32'(out_valid), 32'd0);
        check("t6.out_data",  out_data,       32'd0);
        check("t6.owner",     32'(owner),     32'd0);
        rst = 1'b0; lock_b = 1'b0;
        grant("t6.first", 1'b1, 1'b0, 1'b0);
        tick();
        check("t6.first_data", out_data, 32'hA000_0004);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
